// File: rtl/ref_scheduler_pkg.sv
// Shared types and defaults for the SDRAM refresh scheduler.
// Optional urgent flag is enabled with the REF_URGENT_EN macro.
package ref_scheduler_pkg;

   typedef enum logic [1:0] {
      REF_OFF   = 2'd0,
      REF_RUN   = 2'd1,
      REF_DRAIN = 2'd2
   } ref_state_e;

   localparam int DEF_TREFI_CYC = 1551;
   localparam int DEF_MAX_PEND  = 8;
   localparam int DEF_URGENT_TH = 6;

endpackage

// File: rtl/ref_interval_cnt.sv
// tREFI interval counter: one-cycle tick every TREFI_CYC cycles of run.
// Counter is cleared and held whenever run is low.
module ref_interval_cnt
   import ref_scheduler_pkg::*;
#(
   parameter int TREFI_CYC = DEF_TREFI_CYC
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int CW = $clog2(TREFI_CYC);
   localparam logic [CW-1:0] LAST = CW'(TREFI_CYC - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!run || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/ref_scheduler.sv
// SDRAM refresh scheduler: credit per tREFI, postponed credits, req/ack drain.
// Define REF_URGENT_EN to add the registered ref_urgent output.
module ref_scheduler
   import ref_scheduler_pkg::*;
#(
   parameter int TREFI_CYC = DEF_TREFI_CYC,
   parameter int MAX_PEND  = DEF_MAX_PEND,
   parameter int URGENT_TH = DEF_URGENT_TH,
   localparam int PEND_W   = $clog2(MAX_PEND + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ref_en,
   input  logic              ref_ack,
   output logic              ref_req,
   output logic [PEND_W-1:0] ref_pend,
   output logic              ref_idle,
   output logic              ref_ovf
`ifdef REF_URGENT_EN
   ,
   output logic              ref_urgent
`endif
);

   localparam logic [PEND_W-1:0] PMAX = PEND_W'(MAX_PEND);

   if (TREFI_CYC < 2 || MAX_PEND < 1 || MAX_PEND > 15 ||
       URGENT_TH < 1 || URGENT_TH > MAX_PEND) begin : g_param_err
      $error("ref_scheduler: parameter out of range");
   end

   ref_state_e        state;
   logic [PEND_W-1:0] pend;
   logic [PEND_W-1:0] pend_nxt;
   logic              ovf_nxt;
   logic              run;
   logic              tick;

   assign run = (state == REF_RUN);

   ref_interval_cnt #(
      .TREFI_CYC(TREFI_CYC)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .run (run),
      .tick(tick)
   );

   // Simultaneous tick and ack cancel out, so saturation cannot overflow then.
   always_comb begin
      pend_nxt = pend;
      ovf_nxt  = ref_ovf;
      unique case (1'b1)
         tick && !ref_ack: begin
            if (pend == PMAX)
               ovf_nxt = 1'b1;
            else
               pend_nxt = pend + 1'b1;
         end
         !tick && ref_ack && (pend != '0):
            pend_nxt = pend - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= REF_OFF;
         pend    <= '0;
         ref_ovf <= 1'b0;
      end else begin
         pend    <= pend_nxt;
         ref_ovf <= ovf_nxt;
         unique case (state)
            REF_OFF:
               if (ref_en) state <= REF_RUN;
            REF_RUN:
               if (!ref_en) state <= REF_DRAIN;
            REF_DRAIN:
               if (ref_en)
                  state <= REF_RUN;
               else if (pend == '0)
                  state <= REF_OFF;
            default:
               state <= REF_OFF;
         endcase
      end
   end

`ifdef REF_URGENT_EN
   localparam logic [PEND_W-1:0] UTH = PEND_W'(URGENT_TH);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ref_urgent <= 1'b0;
      else
         ref_urgent <= (pend_nxt >= UTH);
   end
`endif

   assign ref_req  = (pend != '0);
   assign ref_pend = pend;
   assign ref_idle = (state == REF_OFF) && (pend == '0);

endmodule

// File: tb/tb_ref_scheduler.sv
// Directed bench for ref_scheduler with TREFI_CYC=16, MAX_PEND=4, URGENT_TH=3.
// ref_urgent is only checked when REF_URGENT_EN is defined.
module tb_ref_scheduler;

   logic       clk;
   logic       rst;
   logic       ref_en;
   logic       ref_ack;
   logic       ref_req;
   logic [2:0] ref_pend;
   logic       ref_idle;
   logic       ref_ovf;
`ifdef REF_URGENT_EN
   logic       ref_urgent;
`endif

   int n_chk;
   int n_fail;

   ref_scheduler #(
      .TREFI_CYC(16),
      .MAX_PEND (4),
      .URGENT_TH(3)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .ref_en  (ref_en),
      .ref_ack (ref_ack),
      .ref_req (ref_req),
      .ref_pend(ref_pend),
      .ref_idle(ref_idle),
      .ref_ovf (ref_ovf)
`ifdef REF_URGENT_EN
      ,
      .ref_urgent(ref_urgent)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic en;
      logic ack;
      int   n;
      int   pend;
      logic req;
      logic idle;
      logic ovf;
      logic urg;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input int pend,
                          input logic req, input logic idle,
                          input logic ovf, input logic urg);
      chk({name, ".pend"}, int'(ref_pend), pend);
      chk({name, ".req"}, int'(ref_req), int'(req));
      chk({name, ".idle"}, int'(ref_idle), int'(idle));
      chk({name, ".ovf"}, int'(ref_ovf), int'(ovf));
`ifdef REF_URGENT_EN
      chk({name, ".urg"}, int'(ref_urgent), int'(urg));
`else
      if (urg === 1'bx) $display("note: urg unknown in %s", name);
`endif
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      // t = edges since RUN entry; ticks land on edges 16, 32, ...
      vecs[0]  = '{1'b1, 1'b0, 15, 1, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 16, 2, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 16, 3, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 1'b0, 16, 4, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 15, 4, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1,  4, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 15, 4, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1,  4, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 1,  3, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 1,  2, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1,  2, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 20, 2, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1,  1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1,  0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1,  0, 1'b0, 1'b1, 1'b1, 1'b0};

      rst     = 1'b1;
      ref_en  = 1'b0;
      ref_ack = 1'b0;
      cyc(3);
      chk_all("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);

      // First tick after 16 RUN cycles
      rst    = 1'b0;
      ref_en = 1'b1;
      cyc(1);
      chk("run_entry.idle", int'(ref_idle), 0);
      cyc(15);
      chk_all("pre_tick", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1);
      chk_all("first_tick", 1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Ack right after each request
      ref_ack = 1'b1;
      cyc(1);
      ref_ack = 1'b0;
      chk_all("ack0", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(15);
         chk_all($sformatf("steady_req%0d", i), 1, 1'b1, 1'b0, 1'b0, 1'b0);
         ref_ack = 1'b1;
         cyc(1);
         ref_ack = 1'b0;
         chk_all($sformatf("steady_ack%0d", i), 0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Saturation, tick+ack, drain
      for (int i = 0; i < 15; i++) begin
         ref_en  = vecs[i].en;
         ref_ack = vecs[i].ack;
         cyc(vecs[i].n);
         ref_ack = 1'b0;
         chk_all($sformatf("vec%0d", i), vecs[i].pend, vecs[i].req,
                 vecs[i].idle, vecs[i].ovf, vecs[i].urg);
      end

      // Asynchronous reset mid-RUN at pend=3
      ref_en = 1'b1;
      cyc(1);
      cyc(48);
      chk_all("pre_rst", 3, 1'b1, 1'b0, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 0, 1'b0, 1'b1, 1'b0, 1'b0);
      ref_en = 1'b0;
      cyc(1);
      rst     = 1'b0;
      ref_ack = 1'b1;
      cyc(1);
      ref_ack = 1'b0;
      chk_all("stray_ack", 0, 1'b0, 1'b1, 1'b0, 1'b0);

      // DRAIN entered with nothing owed falls straight to OFF
      ref_en = 1'b1;
      cyc(1);
      chk("short_run.idle", int'(ref_idle), 0);
      ref_en = 1'b0;
      cyc(1);
      chk("drain_empty.idle", int'(ref_idle), 0);
      cyc(1);
      chk_all("off_again", 0, 1'b0, 1'b1, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
